// File: rtl/axil_timer_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axil_timer_gpio
// Brief    : AXI-lite slave with GPIO out/in registers and a 32-bit compare
//            timer raising a registered interrupt.
// Revision : 1.0  initial release
// ============================================================================
module axil_timer_gpio #(
  parameter int ADDR_BITS = 5,
  parameter int GPIO_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [31:0]       s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq
);

  localparam int IDX_W = ADDR_BITS - 2;

  localparam logic [IDX_W-1:0] IDX_GPIO_OUT = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_GPIO_IN  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_COUNT    = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_CMP      = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(5);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  wr_state_t        r_wr_state, w_wr_state_next;
  rd_state_t        r_rd_state, w_rd_state_next;
  logic             r_aw_held, r_w_held;
  logic [IDX_W-1:0] r_awidx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic [1:0]       r_bresp;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  logic [GPIO_W-1:0] r_gpio_out, r_gpio_sync1, r_gpio_sync2;
  logic [2:0]        r_ctrl;
  logic [31:0]       r_count, r_cmp;
  logic              r_match, r_irq;

  logic             w_aw_fire, w_w_fire, w_commit, w_ar_fire;
  logic [IDX_W-1:0] w_wr_idx;
  logic [31:0]      w_wr_data;
  logic [3:0]       w_wr_strb;
  logic             w_wr_err;
  logic             w_wr_gpio, w_wr_ctrl, w_wr_count, w_wr_cmp, w_wr_status;
  logic [31:0]      w_gpio_merged;
  logic             w_hit, w_clr_match;
  logic [31:0]      w_count_next;
  logic [31:0]      w_rd_data;
  logic             w_rd_err;
  logic             w_unused;

  assign w_unused = &{1'b0, s_axi_awaddr[31:ADDR_BITS], s_axi_awaddr[1:0],
                      s_axi_araddr[31:ADDR_BITS], s_axi_araddr[1:0]};

  // A channel accepted on an earlier edge is taken from its latch, otherwise
  // straight from the bus so a same-edge AW+W pair commits immediately.
  assign w_wr_idx  = r_aw_held ? r_awidx : s_axi_awaddr[ADDR_BITS-1:2];
  assign w_wr_data = r_w_held  ? r_wdata : s_axi_wdata;
  assign w_wr_strb = r_w_held  ? r_wstrb : s_axi_wstrb;
  assign w_wr_err  = (w_wr_idx > IDX_STATUS);

  always_comb begin
    w_wr_state_next = r_wr_state;
    s_axi_awready   = 1'b0;
    s_axi_wready    = 1'b0;
    s_axi_bvalid    = 1'b0;
    w_aw_fire       = 1'b0;
    w_w_fire        = 1'b0;
    w_commit        = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        s_axi_awready = !r_aw_held && !rst;
        s_axi_wready  = !r_w_held && !rst;
        w_aw_fire     = s_axi_awvalid && s_axi_awready;
        w_w_fire      = s_axi_wvalid && s_axi_wready;
        if ((r_aw_held || w_aw_fire) && (r_w_held || w_w_fire)) begin
          w_commit        = 1'b1;
          w_wr_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_wr_state_next = WR_IDLE;
      end
      default: w_wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= WR_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awidx    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_next;
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_awidx   <= s_axi_awaddr[ADDR_BITS-1:2];
      end
      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_commit) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      if (s_axi_bvalid && s_axi_bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  assign s_axi_bresp = r_bresp;

  assign w_wr_gpio   = w_commit && (w_wr_idx == IDX_GPIO_OUT);
  assign w_wr_ctrl   = w_commit && (w_wr_idx == IDX_CTRL);
  assign w_wr_count  = w_commit && (w_wr_idx == IDX_COUNT);
  assign w_wr_cmp    = w_commit && (w_wr_idx == IDX_CMP);
  assign w_wr_status = w_commit && (w_wr_idx == IDX_STATUS);

  assign w_gpio_merged = merge_bytes(32'(r_gpio_out), w_wr_data, w_wr_strb);

  assign w_hit       = r_ctrl[0] && (r_count == r_cmp);
  assign w_clr_match = w_wr_status && w_wr_strb[0] && w_wr_data[0];

  // Software load of COUNT overrides both increment and auto-reload.
  always_comb begin
    w_count_next = r_count;
    if (r_ctrl[0]) w_count_next = (w_hit && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
    if (w_wr_count) w_count_next = merge_bytes(r_count, w_wr_data, w_wr_strb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio_out   <= '0;
      r_gpio_sync1 <= '0;
      r_gpio_sync2 <= '0;
      r_ctrl       <= '0;
      r_count      <= '0;
      r_cmp        <= '0;
      r_match      <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_gpio_sync1 <= gpio_in;
      r_gpio_sync2 <= r_gpio_sync1;
      if (w_wr_gpio) r_gpio_out <= w_gpio_merged[GPIO_W-1:0];
      if (w_wr_ctrl && w_wr_strb[0]) r_ctrl <= w_wr_data[2:0];
      if (w_wr_cmp) r_cmp <= merge_bytes(r_cmp, w_wr_data, w_wr_strb);
      r_count <= w_count_next;
      if (w_hit) r_match <= 1'b1;
      else if (w_clr_match) r_match <= 1'b0;
      r_irq <= r_match && r_ctrl[2];
    end
  end

  assign gpio_out = r_gpio_out;
  assign irq      = r_irq;

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (s_axi_araddr[ADDR_BITS-1:2])
      IDX_GPIO_OUT: w_rd_data = 32'(r_gpio_out);
      IDX_GPIO_IN:  w_rd_data = 32'(r_gpio_sync2);
      IDX_CTRL:     w_rd_data = {29'd0, r_ctrl};
      IDX_COUNT:    w_rd_data = r_count;
      IDX_CMP:      w_rd_data = r_cmp;
      IDX_STATUS:   w_rd_data = {31'd0, r_match};
      default:      w_rd_err  = 1'b1;
    endcase
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    s_axi_arready   = 1'b0;
    s_axi_rvalid    = 1'b0;
    w_ar_fire       = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        s_axi_arready = !rst;
        w_ar_fire     = s_axi_arvalid && s_axi_arready;
        if (w_ar_fire) w_rd_state_next = RD_DATA;
      end
      RD_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) w_rd_state_next = RD_IDLE;
      end
      default: w_rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= RD_IDLE;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_state_next;
      if (w_ar_fire) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_timer_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// Randomised scoreboard bench for axil_timer_gpio against a cycle-level
// behavioural model of the register map and timer rules.
module tb_axil_timer_gpio;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] gpio_out, gpio_in;
  logic        irq;

  always #5 clk = ~clk;

  axil_timer_gpio #(.ADDR_BITS(5), .GPIO_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_gpio, m_count, m_cmp, m_s1, m_s2;
  logic [2:0]  m_ctrl;
  logic        m_match, m_irq;
  logic [1:0]  wq[$];
  logic [33:0] rq[$];

  logic        pend_wr = 1'b0, pend_rd = 1'b0;
  logic [31:0] pend_waddr, pend_wdata, pend_raddr;
  logic [3:0]  pend_wstrb;

  logic bp_random = 1'b0, gpio_tog = 1'b0, mon_on = 1'b0;

  function automatic logic [31:0] strobe(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] a);
    case (a[4:2])
      3'd0: return {2'b00, m_gpio};
      3'd1: return {2'b00, m_s2};
      3'd2: return {2'b00, 29'd0, m_ctrl};
      3'd3: return {2'b00, m_count};
      3'd4: return {2'b00, m_cmp};
      3'd5: return {2'b00, 31'd0, m_match};
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  task automatic model_step();
    logic        hit, nm, ni;
    logic [31:0] nc;
    if (rst) begin
      m_gpio = 0; m_count = 0; m_cmp = 0; m_s1 = 0; m_s2 = 0;
      m_ctrl = 0; m_match = 0; m_irq = 0;
      pend_wr = 0; pend_rd = 0;
      return;
    end
    ni = m_match && m_ctrl[2];
    if (pend_rd) begin
      rq.push_back(model_read(pend_raddr));
      pend_rd = 0;
    end
    hit = m_ctrl[0] && (m_count == m_cmp);
    nc  = !m_ctrl[0] ? m_count : ((hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1);
    nm  = m_match || hit;
    if (pend_wr) begin
      wq.push_back((pend_waddr[4:2] > 3'd5) ? 2'b10 : 2'b00);
      case (pend_waddr[4:2])
        3'd0: m_gpio = strobe(m_gpio, pend_wdata, pend_wstrb);
        3'd2: if (pend_wstrb[0]) m_ctrl = pend_wdata[2:0];
        3'd3: nc = strobe(m_count, pend_wdata, pend_wstrb);
        3'd4: m_cmp = strobe(m_cmp, pend_wdata, pend_wstrb);
        3'd5: if (pend_wstrb[0] && pend_wdata[0] && !hit) nm = 1'b0;
        default: ;
      endcase
      pend_wr = 0;
    end
    m_count = nc;
    m_match = nm;
    m_irq   = ni;
    m_s2    = m_s1;
    m_s1    = gpio_in;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: pops the scoreboard whenever a response handshake is presented.
  initial forever begin
    logic [1:0]  eb;
    logic [33:0] er;
    @(negedge clk);
    if (s_axi_bvalid && s_axi_bready) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL bresp_unexpected: got bvalid with bresp %h, required no response", s_axi_bresp);
      end else begin
        eb = wq.pop_front();
        chk("bresp", {30'd0, s_axi_bresp}, {30'd0, eb});
      end
    end
    if (s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdata_unexpected: got rvalid with rdata %h, required no response", s_axi_rdata);
      end else begin
        er = rq.pop_front();
        chk("rresp", {30'd0, s_axi_rresp}, {30'd0, er[33:32]});
        chk("rdata", s_axi_rdata, er[31:0]);
      end
    end
    if (mon_on) begin
      chk("gpio_out", gpio_out, m_gpio);
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (bp_random) begin
      s_axi_bready = ($urandom_range(0, 2) != 0);
      s_axi_rready = ($urandom_range(0, 2) != 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (gpio_tog && $urandom_range(0, 3) == 0) gpio_in = $urandom();
  end

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lead);
    bit aw_done, w_done;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    while (!(aw_done && w_done)) begin
      s_axi_awvalid = !aw_done && (cyc >= lead);
      s_axi_wvalid  = !w_done && (cyc >= -lead);
      @(negedge clk);
      if (s_axi_awvalid && s_axi_awready) aw_done = 1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1;
      if (aw_done && w_done) begin
        pend_waddr = a; pend_wdata = d; pend_wstrb = s; pend_wr = 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400 && !(aw_done && w_done)) begin
        checks++; errors++;
        $display("FAIL write_timeout: addr %h got no handshake in %0d cycles, required one", a, cyc);
        break;
      end
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
  endtask

  task automatic do_read(input logic [31:0] a);
    int cyc;
    cyc = 0;
    s_axi_araddr = a;
    s_axi_arvalid = 1;
    forever begin
      @(negedge clk);
      if (s_axi_arready) begin
        pend_raddr = a; pend_rd = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400) begin
        checks++; errors++;
        $display("FAIL read_timeout: addr %h got no arready in %0d cycles, required one", a, cyc);
        break;
      end
    end
    s_axi_arvalid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; gpio_in = 0;
    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;

    repeat (2) begin
      @(posedge clk); #1;
      s_axi_awaddr = $urandom(); s_axi_awvalid = 1'($urandom());
      s_axi_wdata = $urandom(); s_axi_wstrb = 4'($urandom()); s_axi_wvalid = 1'($urandom());
      s_axi_araddr = $urandom(); s_axi_arvalid = 1'($urandom());
      s_axi_bready = 1'($urandom()); s_axi_rready = 1'($urandom());
      @(negedge clk);
      chk("rst_awready", {31'd0, s_axi_awready}, 0);
      chk("rst_wready", {31'd0, s_axi_wready}, 0);
      chk("rst_arready", {31'd0, s_axi_arready}, 0);
      chk("rst_bvalid", {31'd0, s_axi_bvalid}, 0);
      chk("rst_rvalid", {31'd0, s_axi_rvalid}, 0);
      chk("rst_irq", {31'd0, irq}, 0);
      chk("rst_gpio_out", gpio_out, 0);
      chk("rst_rdata", s_axi_rdata, 0);
      chk("rst_bresp", {30'd0, s_axi_bresp}, 0);
      chk("rst_rresp", {30'd0, s_axi_rresp}, 0);
    end
    @(posedge clk); #1;
    rst = 0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    s_axi_bready = 1; s_axi_rready = 1;
    @(negedge clk);
    chk("post_rst_awready", {31'd0, s_axi_awready}, 1);
    chk("post_rst_wready", {31'd0, s_axi_wready}, 1);
    chk("post_rst_arready", {31'd0, s_axi_arready}, 1);
    mon_on = 1;
    @(posedge clk); #1;

    do_write(32'h0000_0000, 32'hA5A5_1234, 4'b0101, 0);
    chk("gpio_strobed", gpio_out, 32'h00A5_0034);
    do_read(32'h0000_0000);

    gpio_in = 32'hCAFE_F00D;
    do_read(32'h0000_0004);
    repeat (3) @(posedge clk);
    #1;
    do_read(32'h0000_0004);

    // W leads AW by 3 cycles; B held off for 5 cycles while a second write waits.
    s_axi_bready = 0;
    do_write(32'h0000_0010, 32'h0000_0009, 4'hF, 3);
    fork
      do_write(32'h0000_0000, 32'h1111_2222, 4'hF, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bvalid_held", {31'd0, s_axi_bvalid}, 1);
          chk("awready_blocked", {31'd0, s_axi_awready}, 0);
          chk("wready_blocked", {31'd0, s_axi_wready}, 0);
        end
        @(posedge clk); #1;
        s_axi_bready = 1;
      end
    join
    do_read(32'h0000_0010);

    // Timer: CMP=5, COUNT=0, then CTRL=enable|auto_reload|irq_en.
    do_write(32'h10, 32'd5, 4'hF, 0);
    do_write(32'h0C, 32'd0, 4'hF, -2);
    do_write(32'h14, 32'd1, 4'hF, 0);
    do_write(32'h08, 32'd7, 4'hF, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 6) chk("irq_before_match", {31'd0, irq}, 0);
      if (k == 7) chk("irq_after_match", {31'd0, irq}, 1);
    end
    @(posedge clk); #1;
    repeat (4) do_read(32'h0C);
    do_read(32'h14);

    // CMP=COUNT=0 with reload matches every edge, so W1C always coincides.
    do_write(32'h10, 32'd0, 4'hF, 0);
    do_write(32'h0C, 32'd0, 4'hF, 0);
    do_write(32'h14, 32'd1, 4'h1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("irq_match_wins", {31'd0, irq}, 1);
    end
    @(posedge clk); #1;
    do_read(32'h14);
    do_write(32'h08, 32'd4, 4'hF, 0);
    do_write(32'h14, 32'd1, 4'h2, 0);
    do_read(32'h14);
    do_write(32'h14, 32'd1, 4'h1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("irq_after_w1c", {31'd0, irq}, 0);
    @(posedge clk); #1;
    do_read(32'h14);

    do_write(32'h18, 32'hFFFF_FFFF, 4'hF, 0);
    do_read(32'h1C);
    do_read(32'h18);

    // Wrap: COUNT=0xFFFFFFFE, CMP=3, enable only.
    do_write(32'h08, 32'd0, 4'hF, 0);
    do_write(32'h0C, 32'hFFFF_FFFE, 4'hF, 0);
    do_write(32'h10, 32'd3, 4'hF, 0);
    do_write(32'h08, 32'd1, 4'hF, 0);
    repeat (4) do_read(32'h0C);
    do_write(32'h0C, 32'h10, 4'hF, 0);
    do_read(32'h0C);

    bp_random = 1;
    gpio_tog = 1;
    fork
      repeat (80) begin
        int idx, lead;
        logic [31:0] a, d;
        idx  = $urandom_range(0, 7);
        a    = ($urandom() & 32'hFFFF_FFE0) | (32'(idx) << 2) | ($urandom() & 32'h3);
        d    = (idx == 3 || idx == 4) ? 32'($urandom_range(0, 40)) :
               (idx == 2) ? 32'($urandom_range(0, 7)) : $urandom();
        lead = $urandom_range(0, 4) - 2;
        do_write(a, d, 4'($urandom()), lead);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      repeat (80) begin
        int idx;
        idx = $urandom_range(0, 7);
        do_read(($urandom() & 32'hFFFF_FFE0) | (32'(idx) << 2) | ($urandom() & 32'h3));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    join
    bp_random = 0;
    gpio_tog = 0;
    s_axi_bready = 1;
    s_axi_rready = 1;
    for (int i = 0; i < 100 && (wq.size() != 0 || rq.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("wq_drained", 32'(wq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
